// File: rtl/busca_binaria_sar.sv
// Successive-approximation search controller driving a magnitude comparator.
// Optional comparator one-hot consistency check enabled by defining BUSCA_CHECK_EN.
module busca_binaria_sar #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [WIDTH-1:0]         cand,
    input  logic                     aeqb,
    input  logic                     agtb,
    input  logic                     altb,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic [$clog2(WIDTH):0]   steps,
    output logic                     err
);

    localparam int IW = $clog2(WIDTH);
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {S_IDLE, S_TEST, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  cand_reg, cand_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic [SW-1:0]     steps_reg, steps_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic              err_reg, err_next;

    logic [WIDTH-1:0]  trial_c;
    logic [WIDTH-1:0]  next_bit;
    logic              abort;

    // Per-bit trial decision: only the bit under test may be cleared, and the
    // next lower bit becomes the following trial bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            assign trial_c[gi]  = (32'(idx_reg) == 32'(gi)) ? (cand_reg[gi] & ~agtb) : cand_reg[gi];
            assign next_bit[gi] = (32'(idx_reg) == 32'(gi + 1));
        end
    endgenerate

`ifdef BUSCA_CHECK_EN
    assign abort = ~$onehot({aeqb, agtb, altb});
`else
    // Without the check, altb carries no extra information: anything not aeqb/agtb keeps the bit.
    logic unused_altb;
    assign unused_altb = altb;
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cand_reg   <= '0;
            result_reg <= '0;
            steps_reg  <= '0;
            idx_reg    <= IW'(WIDTH - 1);
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cand_reg   <= cand_next;
            result_reg <= result_next;
            steps_reg  <= steps_next;
            idx_reg    <= idx_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cand_next   = cand_reg;
        result_next = result_reg;
        steps_next  = steps_reg;
        idx_next    = idx_reg;
        err_next    = err_reg;
        case (state_reg)
            S_IDLE: begin
                cand_next = '0;
                if (start) begin
                    cand_next  = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_next   = IW'(WIDTH - 1);
                    steps_next = '0;
                    err_next   = 1'b0;
                    state_next = S_TEST;
                end
            end
            S_TEST: begin
                steps_next = steps_reg + SW'(1);
                if (abort) begin
                    err_next    = 1'b1;
                    result_next = '0;
                    state_next  = S_DONE;
                end else if (aeqb) begin
                    result_next = cand_reg;
                    state_next  = S_DONE;
                end else if (idx_reg == '0) begin
                    result_next = trial_c;
                    state_next  = S_DONE;
                end else begin
                    cand_next = trial_c | next_bit;
                    idx_next  = idx_reg - IW'(1);
                end
            end
            S_DONE: begin
                cand_next  = '0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign cand   = cand_reg;
    assign result = result_reg;
    assign steps  = steps_reg;
    assign err    = err_reg;
    assign busy   = (state_reg == S_TEST);
    assign done   = (state_reg == S_DONE);

endmodule

// File: tb/tb_busca_binaria_sar.sv
// Bench for busca_binaria_sar: ideal comparator on a/b, arithmetic reference of the
// binary search, directed corner cases followed by random targets.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert (32'(obs) === 32'(exp)) else begin \
            failures++; \
            $error("FAIL %s observed=%0d expected=%0d", tag, 32'(obs), 32'(exp)); \
        end \
    end

module tb_busca_binaria_sar;

    localparam int W  = 4;
    localparam int SW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  cand;
    logic          aeqb, agtb, altb;
    logic          busy, done, err;
    logic [W-1:0]  result;
    logic [SW-1:0] steps;

    logic [W-1:0]  target = '0;
    logic          force_on = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Ideal comparator, optionally forced to an inconsistent agtb=altb=1 pattern.
    assign aeqb = force_on ? 1'b0 : (cand == target);
    assign agtb = force_on ? 1'b1 : (cand >  target);
    assign altb = force_on ? 1'b1 : (cand <  target);

    busca_binaria_sar #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cand(cand),
        .aeqb(aeqb), .agtb(agtb), .altb(altb),
        .busy(busy), .done(done), .result(result), .steps(steps), .err(err)
    );

    // i-th candidate of a binary search: the target's top i-1 bits plus trial bit W-i.
    function automatic int exp_cand(input int t, input int i);
        int sh;
        sh = W - i + 1;
        return ((t >> sh) << sh) | (1 << (W - i));
    endfunction

    // Search ends when the lowest set bit of the target is hit; zero needs every step.
    function automatic int exp_steps(input int t);
        int tz;
        if (t == 0) return W;
        tz = 0;
        while (((t >> tz) & 1) == 0) tz++;
        return W - tz;
    endfunction

    task automatic run_search(input int tgt, input int mtgt, input int exp_k, input int exp_res,
                              input int exp_err, input bit hold, input int force_step,
                              input int rst_step);
        int k;
        bit fin;
        target = W'(tgt);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        k = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < W + 2 && !fin; cyc++) begin
            if (busy) begin
                k++;
                `CHK("cand", cand, exp_cand(mtgt, k))
                `CHK("done_in_test", done, 0)
                if (k == rst_step) begin
                    rst_n = 1'b0;
                    #1;
                    `CHK("rst_cand", cand, 0)
                    `CHK("rst_busy", busy, 0)
                    `CHK("rst_done", done, 0)
                    `CHK("rst_result", result, 0)
                    `CHK("rst_steps", steps, 0)
                    `CHK("rst_err", err, 0)
                    start = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                force_on = (k == force_step);
                @(negedge clk);
            end else begin
                force_on = 1'b0;
                start = 1'b0;
                `CHK("done_pulse", done, 1)
                `CHK("test_cycles", k, exp_k)
                `CHK("steps", steps, exp_k)
                `CHK("result", result, exp_res)
                `CHK("err", err, exp_err)
                fin = 1'b1;
            end
        end
        force_on = 1'b0;
        start = 1'b0;
        checks++;
        assert (fin) else begin
            failures++;
            $error("FAIL timeout observed=no_done expected=done_within_%0d", W + 2);
        end
        @(negedge clk);
        `CHK("done_one_cycle", done, 0)
        `CHK("idle_busy", busy, 0)
        `CHK("idle_cand", cand, 0)
        `CHK("result_held", result, exp_res)
        `CHK("steps_held", steps, exp_k)
        $display("search target=%0d result=%0d steps=%0d err=%0d", tgt, result, steps, err);
    endtask

    initial begin
        int t;
        #1;
        `CHK("reset_cand", cand, 0)
        `CHK("reset_busy", busy, 0)
        `CHK("reset_done", done, 0)
        `CHK("reset_result", result, 0)
        `CHK("reset_steps", steps, 0)
        `CHK("reset_err", err, 0)
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_search(9, 9, 4, 9, 0, 1'b0, 0, 0);
        run_search(8, 8, 1, 8, 0, 1'b0, 0, 0);
        run_search(0, 0, 4, 0, 0, 1'b0, 0, 0);
        run_search(15, 15, 4, 15, 0, 1'b1, 0, 0);
        run_search(5, 5, 0, 0, 0, 1'b0, 0, 2);
        run_search(5, 5, 4, 5, 0, 1'b0, 0, 0);
`ifdef BUSCA_CHECK_EN
        run_search(10, 10, 1, 0, 1, 1'b0, 1, 0);
`else
        // Forced agtb on the first step drops bit 3, so the search converges on 7.
        run_search(10, 7, 4, 7, 0, 1'b0, 1, 0);
`endif
        for (int n = 0; n < 20; n++) begin
            t = int'($urandom_range(0, (1 << W) - 1));
            run_search(t, t, exp_steps(t), t, 0, 1'b0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
